// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C byte receiver.
// State encoding, default address and field widths live here.
package i2c_pkg;

    localparam int ADDR_BITS = 7;
    localparam int DATA_BITS = 8;

    localparam logic [ADDR_BITS-1:0] DEFAULT_DEVICE_ADDR = 7'h2A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_DATA,
        ST_DATA_ACK,
        ST_IGNORE
    } state_e;

endpackage

// File: rtl/i2c_edge_detect.sv
// SCL edge detector: compares synchronized SCL with a one-cycle-old copy.
// The delayed copy resets high so an idle bus shows no spurious edge.
module i2c_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic scl,
    output logic rise,
    output logic fall
);

    logic scl_q;

    // Delayed copy of SCL.
    always_ff @(posedge clk) begin
        if (reset) scl_q <= 1'b1;
        else       scl_q <= scl;
    end

    assign rise = scl & ~scl_q;
    assign fall = ~scl & scl_q;

endmodule

// File: rtl/i2c_byte_receiver.sv
// I2C write-only peripheral receiver with a one-byte output buffer.
// I2C_RX_ADDR_FILTER_EN: match DEVICE_ADDR; undefined ACKs any write address.
module i2c_byte_receiver
    import i2c_pkg::*;
#(
    parameter logic [ADDR_BITS-1:0] DEVICE_ADDR = DEFAULT_DEVICE_ADDR
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 scl_sync,
    input  logic                 sda_sync,
    input  logic                 start_pulse,
    input  logic                 stop_pulse,
    output logic                 sda_oe,
    output logic [DATA_BITS-1:0] byte_data,
    output logic                 byte_valid,
    input  logic                 byte_ready,
    output logic                 frame_start,
    output logic                 overrun
);

`ifdef I2C_RX_ADDR_FILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif

    logic scl_rise;
    logic scl_fall;

    i2c_edge_detect u_edge (
        .clk   (clk),
        .reset (reset),
        .scl   (scl_sync),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    state_e               state_q;
    logic [2:0]           cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 sda_oe_q;
    logic                 valid_q;
    logic                 fs_q;
    logic                 ovr_q;
    logic                 ack_on_q;
    logic                 first_q;

    logic [DATA_BITS-1:0] shift_d;
    logic                 last_bit;
    logic                 addr_ok;
    logic                 can_load;

    assign shift_d  = {shift_q[DATA_BITS-2:0], sda_sync};
    assign last_bit = (cnt_q == 3'd7);
    assign addr_ok  = (shift_d[0] == 1'b0) &&
                      (!FILTER_EN || (shift_d[7:1] == DEVICE_ADDR));
    assign can_load = !valid_q || byte_ready;

    // Protocol FSM with registered outputs and output-buffer handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 3'd0;
            shift_q  <= '0;
            data_q   <= '0;
            sda_oe_q <= 1'b0;
            valid_q  <= 1'b0;
            fs_q     <= 1'b0;
            ovr_q    <= 1'b0;
            ack_on_q <= 1'b0;
            first_q  <= 1'b0;
        end else begin
            fs_q <= 1'b0;
            if (valid_q && byte_ready) valid_q <= 1'b0;

            if (start_pulse) begin
                state_q  <= ST_ADDR;
                cnt_q    <= 3'd0;
                shift_q  <= '0;
                sda_oe_q <= 1'b0;
                ack_on_q <= 1'b0;
            end else if (stop_pulse) begin
                state_q  <= ST_IDLE;
                cnt_q    <= 3'd0;
                shift_q  <= '0;
                sda_oe_q <= 1'b0;
                ack_on_q <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_ADDR: begin
                        if (scl_rise) begin
                            shift_q <= shift_d;
                            cnt_q   <= cnt_q + 3'd1;
                            if (last_bit) begin
                                state_q  <= addr_ok ? ST_ADDR_ACK : ST_IGNORE;
                                ack_on_q <= 1'b0;
                                first_q  <= 1'b1;
                            end
                        end
                    end
                    ST_ADDR_ACK, ST_DATA_ACK: begin
                        if (scl_fall) begin
                            if (!ack_on_q) begin
                                sda_oe_q <= 1'b1;
                                ack_on_q <= 1'b1;
                            end else begin
                                sda_oe_q <= 1'b0;
                                ack_on_q <= 1'b0;
                                state_q  <= ST_DATA;
                                cnt_q    <= 3'd0;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (scl_rise) begin
                            shift_q <= shift_d;
                            cnt_q   <= cnt_q + 3'd1;
                            if (last_bit) begin
                                first_q <= 1'b0;
                                if (can_load) begin
                                    data_q   <= shift_d;
                                    valid_q  <= 1'b1;
                                    fs_q     <= first_q;
                                    ack_on_q <= 1'b0;
                                    state_q  <= ST_DATA_ACK;
                                end else begin
                                    ovr_q <= 1'b1;
                                end
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign sda_oe      = sda_oe_q;
    assign byte_data   = data_q;
    assign byte_valid  = valid_q;
    assign frame_start = fs_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_i2c_byte_receiver.sv
// Bench for i2c_byte_receiver: randomized write/read frames against a
// frame-level model of ACKs, delivered bytes, frame_start and overrun.
module tb_i2c_byte_receiver;

    localparam int H = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       scl_sync;
    logic       sda_sync;
    logic       start_pulse;
    logic       stop_pulse;
    logic       sda_oe;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;
    logic       frame_start;
    logic       overrun;

    always #5 clk = ~clk;

    i2c_byte_receiver #(.DEVICE_ADDR(7'h2A)) dut (
        .clk         (clk),
        .reset       (reset),
        .scl_sync    (scl_sync),
        .sda_sync    (sda_sync),
        .start_pulse (start_pulse),
        .stop_pulse  (stop_pulse),
        .sda_oe      (sda_oe),
        .byte_data   (byte_data),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .frame_start (frame_start),
        .overrun     (overrun)
    );

`ifdef I2C_RX_ADDR_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    typedef struct {
        logic [7:0] data;
        bit         first;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] seen_q[$];
    int         fs_exp = 0;
    int         fs_seen = 0;
    bit         ovr_exp = 1'b0;
    int         checks = 0;
    int         passes = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      name, act, exp, $time);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Output-buffer monitor: every valid cycle must show the modelled byte.
    always @(negedge clk) begin
        if (!reset) begin
            if (frame_start) begin
                fs_seen++;
                chk("frame_start_first",
                    {31'd0, (exp_q.size() > 0 && exp_q[0].first)}, 1);
            end
            if (byte_valid) begin
                chk("byte_valid_expected", {31'd0, exp_q.size() > 0}, 1);
                if (exp_q.size() > 0) begin
                    chk("byte_data", {24'd0, byte_data},
                        {24'd0, exp_q[0].data});
                    if (byte_ready) begin
                        seen_q.push_back(byte_data);
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic start_cond();
        scl_sync = 1'b1;
        sda_sync = 1'b1;
        tick(H);
        sda_sync    = 1'b0;
        start_pulse = 1'b1;
        tick(1);
        start_pulse = 1'b0;
        tick(H);
    endtask

    task automatic stop_cond();
        scl_sync = 1'b0;
        tick(H);
        chk("oe_release", {31'd0, sda_oe}, 0);
        sda_sync = 1'b0;
        tick(H);
        scl_sync = 1'b1;
        tick(H);
        sda_sync   = 1'b1;
        stop_pulse = 1'b1;
        tick(1);
        stop_pulse = 1'b0;
        tick(H);
    endtask

    task automatic send_bits(input logic [7:0] v, input int n);
        for (int i = 7; i >= 8 - n; i--) begin
            scl_sync = 1'b0;
            tick(H);
            sda_sync = v[i];
            tick(H);
            scl_sync = 1'b1;
            tick(H);
            chk("oe_data_bit", {31'd0, sda_oe}, 0);
            tick(H);
        end
    endtask

    task automatic ack_slot(input bit exp_ack);
        scl_sync = 1'b0;
        tick(H);
        sda_sync = 1'b1;
        tick(H);
        chk("ack_low", {31'd0, sda_oe}, {31'd0, exp_ack});
        scl_sync = 1'b1;
        tick(H);
        chk("ack_high", {31'd0, sda_oe}, {31'd0, exp_ack});
        tick(H);
    endtask

    task automatic release_buf();
        byte_ready = 1'b1;
        tick(4);
    endtask

    // One write/read frame; model decides ACKs and which bytes are kept.
    task automatic frame(input logic [6:0] a, input bit rw, input int n,
                         input logic [7:0] d0, input logic [7:0] d1,
                         input logic [7:0] d2, input bit rdy);
        bit         ok;
        bit         pend;
        bit         ea;
        logic [7:0] dv;
        byte_ready = rdy;
        ok   = !rw && (!FILT || a == 7'h2A);
        pend = 1'b0;
        start_cond();
        send_bits({a, rw}, 8);
        ack_slot(ok);
        for (int i = 0; i < n; i++) begin
            dv = (i == 0) ? d0 : (i == 1) ? d1 : d2;
            ea = 1'b0;
            if (ok) begin
                if (!pend || rdy) begin
                    exp_q.push_back('{data: dv, first: (i == 0)});
                    if (i == 0) fs_exp++;
                    ea   = 1'b1;
                    pend = !rdy;
                end else begin
                    ovr_exp = 1'b1;
                end
            end
            send_bits(dv, 8);
            ack_slot(ea);
        end
        stop_cond();
        chk("overrun", {31'd0, overrun}, {31'd0, ovr_exp});
        chk("frame_start_count", fs_seen, fs_exp);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_sda_oe"}, {31'd0, sda_oe}, 0);
        chk({tag, "_byte_data"}, {24'd0, byte_data}, 0);
        chk({tag, "_byte_valid"}, {31'd0, byte_valid}, 0);
        chk({tag, "_frame_start"}, {31'd0, frame_start}, 0);
        chk({tag, "_overrun"}, {31'd0, overrun}, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n0;
        int f0;
        reset       = 1'b1;
        scl_sync    = 1'b1;
        sda_sync    = 1'b1;
        start_pulse = 1'b0;
        stop_pulse  = 1'b0;
        byte_ready  = 1'b1;
        tick(3);
        check_reset_values("reset");
        reset = 1'b0;
        tick(3);

        // Write 0x2A: 0xA5, 0x3C.
        seen_q.delete();
        f0 = fs_seen;
        frame(7'h2A, 1'b0, 2, 8'hA5, 8'h3C, 8'h00, 1'b1);
        chk("wr_count", seen_q.size(), 2);
        if (seen_q.size() == 2) begin
            chk("wr_byte0", {24'd0, seen_q[0]}, 32'hA5);
            chk("wr_byte1", {24'd0, seen_q[1]}, 32'h3C);
        end
        chk("wr_fs_once", fs_seen - f0, 1);

        // Address 0x2B.
        n0 = seen_q.size();
        frame(7'h2B, 1'b0, 1, 8'h99, 8'h00, 8'h00, 1'b1);
        chk("addr2b_bytes", seen_q.size() - n0, FILT ? 0 : 1);

        // Read from 0x2A.
        n0 = seen_q.size();
        frame(7'h2A, 1'b1, 1, 8'h66, 8'h00, 8'h00, 1'b1);
        chk("read_bytes", seen_q.size() - n0, 0);

        // Buffer held: second byte dropped.
        frame(7'h2A, 1'b0, 2, 8'h11, 8'h22, 8'h00, 1'b0);
        chk("hold_data", {24'd0, byte_data}, 32'h11);
        chk("hold_valid", {31'd0, byte_valid}, 1);
        chk("overrun_set", {31'd0, overrun}, 1);
        release_buf();
        chk("hold_drained", exp_q.size(), 0);

        // Repeated START after 4 data bits.
        n0 = seen_q.size();
        start_cond();
        send_bits({7'h2A, 1'b0}, 8);
        ack_slot(1'b1);
        send_bits(8'hF0, 4);
        start_cond();
        send_bits({7'h2A, 1'b0}, 8);
        ack_slot(1'b1);
        exp_q.push_back('{data: 8'h77, first: 1'b1});
        fs_exp++;
        send_bits(8'h77, 8);
        ack_slot(1'b1);
        stop_cond();
        chk("rs_count", seen_q.size() - n0, 1);
        if (seen_q.size() == n0 + 1)
            chk("rs_byte", {24'd0, seen_q[n0]}, 32'h77);
        chk("rs_fs_count", fs_seen, fs_exp);

        // Randomized frames.
        for (int k = 0; k < 30; k++) begin
            logic [6:0] a;
            bit         rw;
            bit         rdy;
            int         n;
            a   = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h2A;
            rw  = ($urandom_range(0, 4) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            n   = rdy ? $urandom_range(1, 3) : $urandom_range(1, 2);
            frame(a, rw, n, 8'($urandom), 8'($urandom), 8'($urandom), rdy);
            if (!rdy) release_buf();
            chk("rand_drained", exp_q.size(), 0);
        end

        // Reset while ACKing a data byte.
        start_cond();
        send_bits({7'h2A, 1'b0}, 8);
        ack_slot(1'b1);
        exp_q.push_back('{data: 8'h5A, first: 1'b1});
        fs_exp++;
        send_bits(8'h5A, 8);
        scl_sync = 1'b0;
        tick(H);
        chk("oe_before_reset", {31'd0, sda_oe}, 1);
        reset    = 1'b1;
        scl_sync = 1'b1;
        sda_sync = 1'b1;
        tick(1);
        reset   = 1'b0;
        ovr_exp = 1'b0;
        check_reset_values("midreset");
        tick(2 * H);
        chk("post_reset_oe", {31'd0, sda_oe}, 0);
        chk("final_fs_count", fs_seen, fs_exp);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/i2c_byte_receiver.md
I2C_BYTE_RECEIVER -- requirements
Module: i2c_byte_receiver

Interface
REQ-001 SHALL have parameter DEVICE_ADDR, default 7'h2A, the 7-bit peripheral address this block acknowledges.
REQ-002 SHALL have port clk  input  1  system clock; all logic is on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port scl_sync  input  1  SCL, already synchronized to clk by the upstream sampler.
REQ-005 SHALL have port sda_sync  input  1  SDA, already synchronized to clk.
REQ-006 SHALL have port start_pulse  input  1  one-cycle strobe for START or repeated START.
REQ-007 SHALL have port stop_pulse  input  1  one-cycle strobe for STOP.
REQ-008 SHALL have port sda_oe  output  1  1 = pull SDA low (ACK).
REQ-009 SHALL have port byte_data  output  8  received data byte, MSB first on the wire.
REQ-010 SHALL have port byte_valid  output  1  byte_data is valid.
REQ-011 SHALL have port byte_ready  input  1  consumer accepts byte_data.
REQ-012 SHALL have port frame_start  output  1  one-cycle pulse: first data byte of a write frame is on byte_data.
REQ-013 SHALL have port overrun  output  1  sticky flag: a byte was dropped because the buffer was full.

Function
REQ-014 SHALL detect SCL edges by comparing scl_sync with a one-cycle-delayed copy; rise = 0->1, fall = 1->0.
REQ-015 SHALL have states IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
REQ-016 From any state, start_pulse SHALL go to ADDR with bit counter 0, shift register 0, and sda_oe 0 in the next cycle.
REQ-017 From any state, stop_pulse SHALL go to IDLE with sda_oe 0; start_pulse takes priority if both pulses occur in the same cycle.
REQ-018 In ADDR and DATA, each SCL rise SHALL shift sda_sync into the LSB of an 8-bit shift register and increment a 3-bit counter.
REQ-019 After the 8th rise in ADDR: if bits[7:1]==DEVICE_ADDR and bit0==0 (write), the FSM SHALL go to ADDR_ACK; otherwise it SHALL go to IGNORE.
REQ-020 In ADDR_ACK and DATA_ACK, sda_oe SHALL assert on the first SCL fall after entry and deassert on the next SCL fall; the FSM then goes to DATA with the counter at 0.
REQ-021 After the 8th rise in DATA with byte_valid==0 (or byte_valid && byte_ready in that same cycle), the byte SHALL load into byte_data with byte_valid=1 one cycle later; the FSM then goes to DATA_ACK.
REQ-022 After the 8th rise in DATA with byte_valid==1 and byte_ready==0, the byte SHALL be dropped, overrun SHALL set, and the FSM SHALL go to DATA without ACK (NACK); sda_oe stays 0 for that ACK slot.
REQ-023 byte_valid SHALL clear the cycle after byte_valid && byte_ready, unless a new byte loads in that cycle.
REQ-024 frame_start SHALL pulse with the byte_valid rise of the first byte after ADDR_ACK.
REQ-025 IGNORE SHALL keep sda_oe at 0 and ignore SCL until start_pulse or stop_pulse.
REQ-026 A START or STOP in mid-byte SHALL discard the partial byte; a byte already in byte_data is retained.
REQ-027 overrun SHALL clear only on reset.

Reset
REQ-028 On reset: state IDLE, sda_oe=0, byte_data=8'h00, byte_valid=0, frame_start=0, overrun=0, counter=0, shift register=0, delayed SCL=1.
REQ-029 Reset mid-transfer SHALL take effect the next cycle, abandoning the frame and releasing SDA.

Configuration
REQ-030 Macro I2C_RX_ADDR_FILTER_EN defined: address comparison is as in REQ-019.
REQ-031 Macro I2C_RX_ADDR_FILTER_EN undefined: any write address (bit0==0) is ACKed (promiscuous); read addresses still go to IGNORE.

Structure
REQ-032 A shared package i2c_pkg SHALL hold the state enum typedef, the default DEVICE_ADDR, and the ADDR_BITS=7/DATA_BITS=8 constants.
REQ-033 SCL edge detection SHALL be a sub-module named i2c_edge_detect (outputs rise, fall); everything else stays in i2c_byte_receiver.

Verification
REQ-034 Write frame to 0x2A with 0xA5 and 0x3C, byte_ready=1 -> two ACKs on sda_oe; byte_data 0xA5 then 0x3C; frame_start with 0xA5 only.
REQ-035 Address 0x2B (filter enabled) -> no ACK, no byte_valid, state IGNORE until STOP.
REQ-036 Read address 0x55 (0x2A, R) -> NACK, IGNORE.
REQ-037 byte_ready=0, two data bytes 0x11, 0x22 -> byte_data holds 0x11; second slot NACKed; overrun=1.
REQ-038 Repeated START after 4 data bits -> partial byte discarded; new address phase ACKed correctly.
REQ-039 Reset asserted during DATA_ACK with sda_oe=1 -> sda_oe=0, all outputs at reset values the next cycle.
